// File: rtl/cpu_run_pkg.sv
// Shared encodings for the CPU run controller: state, mode and stop-cause codes.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WARMUP    = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_EXEC = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_COUNT = 3'd1;
  localparam logic [2:0] CAUSE_USER  = 3'd2;
  localparam logic [2:0] CAUSE_CPU   = 3'd3;
  localparam logic [2:0] CAUSE_BP    = 3'd4;

  // Where a run lands once warm-up is over; a zero-length counted run halts at once.
  function automatic state_t post_warm(input logic [1:0] m, input logic len_zero);
    if (m == MODE_COUNT && len_zero) return ST_HALTED;
    if (m == MODE_STEP)              return ST_STEP_WAIT;
    return ST_RUN;
  endfunction

endpackage

// File: rtl/cpu_run_cnt.sv
// Saturating enabled-cycle counter with synchronous clear and run-length compare.
module cpu_run_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] len,
  output logic [W-1:0] count,
  output logic         at_len
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)                  count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && count != '1)   count <= count + W'(1);
  end

  // True on the cycle whose increment reaches len.
  assign at_len = (count + W'(1)) == len;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller sequencing the CPU enable: warm-up, free/counted/step runs, halt handling.
// Optional PC breakpoint when CPU_RUN_BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int PC_W       = 32,
  parameter int WARMUP_CYC = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic             cpu_halt,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       stop_cause
);

  localparam int WARM_W = (WARMUP_CYC < 2) ? 1 : $clog2(WARMUP_CYC + 1);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP_CYC);

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [2:0]         cause_q, cause_d;
  logic               done_q, step_q;
  logic               cnt_clr, at_len, halt_enter, step_rise, bp_hit;

  assign step_rise = step & ~step_q;

`ifdef CPU_RUN_BREAKPOINT_EN
  assign bp_hit = bp_valid && (pc == bp_addr);
`else
  assign bp_hit = 1'b0 & bp_valid & (pc == bp_addr);
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    warm_d  = warm_q;
    cause_d = cause_q;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          mode_d  = mode;
          len_d   = run_len;
          warm_d  = WARM_INIT;
          cause_d = CAUSE_NONE;
          cnt_clr = 1'b1;
          if (WARMUP_CYC == 0) begin
            state_d = post_warm(mode, run_len == '0);
            if (state_d == ST_HALTED) cause_d = CAUSE_COUNT;
          end else begin
            state_d = ST_WARMUP;
          end
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_USER;
        end else if (warm_q <= WARM_W'(1)) begin
          state_d = post_warm(mode_q, len_q == '0);
          if (state_d == ST_HALTED) cause_d = CAUSE_COUNT;
        end else begin
          warm_d = warm_q - WARM_W'(1);
        end
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CPU;
        end else if (stop) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_USER;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end else if (mode_q == MODE_COUNT && at_len) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_COUNT;
        end
      end
      ST_STEP_WAIT: begin
        if (stop) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_USER;
        end else if (step_rise) begin
          state_d = ST_STEP_EXEC;
        end
      end
      ST_STEP_EXEC: begin
        state_d = ST_STEP_WAIT;
        if (cpu_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_CPU;
        end else if (stop) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_USER;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A restart from HALTED that halts again (zero-length run) is still a fresh entry.
  assign halt_enter = (state_d == ST_HALTED) && ((state_q != ST_HALTED) || start);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FREE;
      len_q   <= '0;
      warm_q  <= '0;
      cause_q <= CAUSE_NONE;
      done_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      warm_q  <= warm_d;
      cause_q <= cause_d;
      done_q  <= halt_enter;
      step_q  <= step;
    end
  end

  cpu_run_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (cnt_clr),
    .inc     (enable),
    .len     (len_q),
    .count   (cycle_count),
    .at_len  (at_len)
  );

  assign enable     = (state_q == ST_RUN) || (state_q == ST_STEP_EXEC);
  assign busy       = (state_q == ST_WARMUP) || (state_q == ST_RUN) ||
                      (state_q == ST_STEP_WAIT) || (state_q == ST_STEP_EXEC);
  assign done       = done_q;
  assign stop_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: vector table, randomized runs vs. an event model, corner sequences.
module tb_cpu_run_ctrl;
  import cpu_run_pkg::*;

  logic        clk = 1'b0;
  logic        clear_n, start, stop, step, cpu_halt, bp_valid;
  logic [1:0]  mode;
  logic [31:0] run_len, pc, bp_addr;
  logic        enable, busy, done;
  logic [31:0] cycle_count;
  logic [2:0]  stop_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .mode        (mode),
    .run_len     (run_len),
    .cpu_halt    (cpu_halt),
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .enable      (enable),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count),
    .stop_cause  (stop_cause)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Outcome of a run from its events: the earliest event wins, ties go to cpu_halt > stop > count.
  // kh/ks give the enabled-cycle index (1-based) at which cpu_halt/stop is raised, 0 = never.
  function automatic void model(input logic [1:0] m, input int len, input int kh, input int ks,
                                output int n, output int cause);
    n = 1 << 20;
    cause = 0;
    if (m == MODE_COUNT) begin n = len; cause = 1; end
    if (ks > 0 && ks <= n) begin n = ks; cause = 2; end
    if (kh > 0 && kh <= n) begin n = kh; cause = 3; end
  endfunction

  // Starts a run and drives cpu_halt/stop on chosen enabled cycles, counting enable and done.
  task automatic run_scenario(input logic [1:0] m, input int len, input int kh, input int ks,
                              input bit junk_start, output int n_en, output int n_done,
                              output int first_en);
    int k = 0;
    int idle = 0;
    n_en = 0; n_done = 0; first_en = -1;
    start = 1'b1; mode = m; run_len = len;
    @(posedge clk); #1;
    start = 1'b0; mode = 2'($urandom); run_len = $urandom_range(0, 3);
    for (int c = 1; c <= 80; c++) begin
      if (enable) begin
        n_en++; k++;
        if (first_en < 0) first_en = c;
      end
      if (done) n_done++;
      cpu_halt = enable && (k == kh);
      stop     = enable && (k == ks);
      start    = enable && junk_start && ($urandom_range(0, 1) == 1);
      if (!busy) idle++;
      if (idle >= 3) break;
      @(posedge clk); #1;
    end
    cpu_halt = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic check_run(input string tag, input int n_en, input int n_done, input int first_en,
                           input int exp_n, input int exp_cause);
    check({tag, " enable cycles"}, n_en, exp_n);
    check({tag, " done pulses"}, n_done, 1);
    check({tag, " first enable"}, first_en, (exp_n > 0) ? 3 : -1);
    check({tag, " cycle_count"}, cycle_count, exp_n);
    check({tag, " stop_cause"}, stop_cause, exp_cause);
    check({tag, " busy after"}, busy, 0);
  endtask

  typedef struct {
    logic [1:0] m;
    int         len;
    int         kh;
    int         ks;
    int         exp_n;
    int         exp_cause;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n_en, n_done, first_en, exp_n, exp_cause, rises;
    logic prev_en;
    logic [1:0] m;
    int len, kh, ks;
    logic pat[13];

    tbl[0] = '{MODE_FREE,  0, 4, 6, 4, 3};
    tbl[1] = '{MODE_COUNT, 5, 0, 0, 5, 1};
    tbl[2] = '{MODE_COUNT, 0, 0, 0, 0, 1};
    tbl[3] = '{MODE_FREE,  0, 3, 3, 3, 3};
    tbl[4] = '{MODE_COUNT, 4, 0, 4, 4, 2};
    tbl[5] = '{MODE_COUNT, 4, 2, 0, 2, 3};
    tbl[6] = '{MODE_RSVD,  0, 0, 7, 7, 2};
    tbl[7] = '{MODE_COUNT, 1, 0, 0, 1, 1};
    tbl[8] = '{MODE_FREE,  0, 0, 1, 1, 2};

    clear_n = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; cpu_halt = 1'b0;
    mode = MODE_FREE; run_len = '0; pc = '0; bp_addr = '0; bp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset enable", enable, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset cycle_count", cycle_count, 0);
    check("reset stop_cause", stop_cause, 0);
    @(negedge clk); clear_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_scenario(tbl[i].m, tbl[i].len, tbl[i].kh, tbl[i].ks, 1'b0, n_en, n_done, first_en);
      check_run($sformatf("vec%0d", i), n_en, n_done, first_en, tbl[i].exp_n, tbl[i].exp_cause);
    end

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 2))
        0:       m = MODE_FREE;
        1:       m = MODE_COUNT;
        default: m = MODE_RSVD;
      endcase
      len = $urandom_range(0, 8);
      kh  = $urandom_range(0, 10);
      ks  = $urandom_range(0, 10);
      if (m != MODE_COUNT && kh == 0 && ks == 0) ks = 5;
      model(m, len, kh, ks, exp_n, exp_cause);
      run_scenario(m, len, kh, ks, 1'b1, n_en, n_done, first_en);
      check_run($sformatf("rnd%0d", i), n_en, n_done, first_en, exp_n, exp_cause);
    end

    // PC parked on the breakpoint address for the whole run.
    bp_valid = 1'b1; bp_addr = 32'h10; pc = 32'h10;
    run_scenario(MODE_FREE, 0, 0, 6, 1'b0, n_en, n_done, first_en);
`ifdef CPU_RUN_BREAKPOINT_EN
    check_run("bp", n_en, n_done, first_en, 1, 4);
`else
    check_run("bp", n_en, n_done, first_en, 6, 2);
`endif
    bp_valid = 1'b0; pc = '0;

    // Single-step: a held step and two separate pulses give three isolated enable cycles.
    start = 1'b1; mode = MODE_STEP;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("step wait busy", busy, 1);
    pat = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    n_en = 0; rises = 0; prev_en = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step = pat[i];
      @(posedge clk); #1;
      if (enable) n_en++;
      if (enable && !prev_en) rises++;
      prev_en = enable;
    end
    check("step enable cycles", n_en, 3);
    check("step enable pulses", rises, 3);
    check("step cycle_count", cycle_count, 3);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("step stop done", done, 1);
    check("step stop_cause", stop_cause, 2);
    check("step stop busy", busy, 0);
    @(posedge clk); #1;
    check("step done single", done, 0);
    check("step final count", cycle_count, 3);

    // start and stop together from HALTED: start wins, then stop lands in warm-up.
    start = 1'b1; stop = 1'b1; mode = MODE_FREE;
    @(posedge clk); #1;
    start = 1'b0;
    check("start wins busy", busy, 1);
    @(posedge clk); #1;
    stop = 1'b0;
    check("warmup stop done", done, 1);
    check("warmup stop_cause", stop_cause, 2);
    check("warmup stop count", cycle_count, 0);
    check("warmup stop enable", enable, 0);

    // Asynchronous clear in the middle of a run.
    start = 1'b1; mode = MODE_FREE;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10 && !enable; c++) begin
      @(posedge clk); #1;
    end
    check("pre-clear enable", enable, 1);
    @(posedge clk); #3;
    clear_n = 1'b0;
    #1;
    check("clear enable", enable, 0);
    check("clear busy", busy, 0);
    check("clear done", done, 0);
    check("clear cycle_count", cycle_count, 0);
    check("clear stop_cause", stop_cause, 0);
    @(negedge clk); clear_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-clear busy", busy, 0);
    check("post-clear enable", enable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
